// File: rtl/iic_slave_reg_ctrl.sv
// rtl/iic_slave_reg_ctrl.sv - register bank behind the I2C slave byte stream, shared with a local host port
// Optional pointer auto-increment: IIC_REG_AUTOINC_EN
module iic_slave_reg_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_wen,
    input  logic [7:0]                       fifo_wdata,
    input  logic                             fifo_wdata_start,
    input  logic                             fifo_ren,
    output logic [7:0]                       fifo_rdata,
    input  logic                             host_req,
    input  logic                             host_we,
    input  logic [ADDR_WIDTH-1:0]            host_addr,
    input  logic [7:0]                       host_wdata,
    output logic                             host_ack,
    output logic [7:0]                       host_rdata,
    output logic                             i2c_wr_strobe,
    output logic [ADDR_WIDTH-1:0]            i2c_wr_addr,
    output logic [8*(2**ADDR_WIDTH)-1:0]     reg_bank
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_bank [DEPTH];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  w_ptr_load;
    logic                  w_i2c_wr;
    logic                  w_ptr_inc;
    logic                  w_host_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_load  = fifo_wen & fifo_wdata_start;
        w_i2c_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ptr_load) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fifo_wen && !fifo_wdata_start) begin
                    w_i2c_wr = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef IIC_REG_AUTOINC_EN
    assign w_ptr_inc = w_i2c_wr | fifo_ren;
`else
    assign w_ptr_inc = 1'b0;
`endif

    // Pointer bytes take precedence; the slave never issues wen and ren together.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_ptr_load) begin
            w_ptr_nxt = fifo_wdata[ADDR_WIDTH-1:0];
        end else if (w_ptr_inc) begin
            w_ptr_nxt = r_ptr + 1'b1;
        end
    end

    // The cycle right after an ack is skipped so a held request is not served twice.
    assign w_host_acc = host_req & ~fifo_wen & ~host_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= '0;
            fifo_rdata    <= '0;
            host_ack      <= 1'b0;
            host_rdata    <= '0;
            i2c_wr_strobe <= 1'b0;
            i2c_wr_addr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_ptr         <= w_ptr_nxt;
            host_ack      <= w_host_acc;
            i2c_wr_strobe <= w_i2c_wr;
            if (w_i2c_wr) begin
                i2c_wr_addr   <= r_ptr;
                r_bank[r_ptr] <= fifo_wdata;
            end else if (w_host_acc && host_we) begin
                r_bank[host_addr] <= host_wdata;
            end
            if (fifo_ren) begin
                fifo_rdata <= r_bank[r_ptr];
            end
            if (w_host_acc && !host_we) begin
                host_rdata <= r_bank[host_addr];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign reg_bank[8*g +: 8] = r_bank[g];
    end

endmodule

// File: tb/tb_iic_slave_reg_ctrl.sv
// tb/tb_iic_slave_reg_ctrl.sv - directed self-checking bench for iic_slave_reg_ctrl
module tb_iic_slave_reg_ctrl;

`ifdef IIC_REG_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_wen;
    logic [7:0]   fifo_wdata;
    logic         fifo_wdata_start;
    logic         fifo_ren;
    logic [7:0]   fifo_rdata;
    logic         host_req;
    logic         host_we;
    logic [3:0]   host_addr;
    logic [7:0]   host_wdata;
    logic         host_ack;
    logic [7:0]   host_rdata;
    logic         i2c_wr_strobe;
    logic [3:0]   i2c_wr_addr;
    logic [127:0] reg_bank;

    logic [7:0]   exp_bank [16];
    logic [7:0]   e8;
    logic [3:0]   e4;
    int           n_vec = 0;
    int           n_err = 0;

    iic_slave_reg_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_wen         (fifo_wen),
        .fifo_wdata       (fifo_wdata),
        .fifo_wdata_start (fifo_wdata_start),
        .fifo_ren         (fifo_ren),
        .fifo_rdata       (fifo_rdata),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_ack         (host_ack),
        .host_rdata       (host_rdata),
        .i2c_wr_strobe    (i2c_wr_strobe),
        .i2c_wr_addr      (i2c_wr_addr),
        .reg_bank         (reg_bank)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_bank[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        fifo_wen = 1'b1;
        fifo_wdata = d;
        fifo_wdata_start = s;
        tick();
        fifo_wen = 1'b0;
        fifo_wdata_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (fifo_rdata !== 8'h00) begin n_err++; $display("FAIL reset_fifo_rdata got %h exp 00", fifo_rdata); end
        n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL reset_host_ack got %b exp 0", host_ack); end
        n_vec++; if (host_rdata !== 8'h00) begin n_err++; $display("FAIL reset_host_rdata got %h exp 00", host_rdata); end
        n_vec++; if (i2c_wr_strobe !== 1'b0 || i2c_wr_addr !== 4'h0) begin n_err++; $display("FAIL reset_strobe got %b/%h exp 0/0", i2c_wr_strobe, i2c_wr_addr); end
        n_vec++; if (reg_bank !== 128'h0) begin n_err++; $display("FAIL reset_bank got %h exp 0", reg_bank); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dropped_and_ptr_mask();
        send(8'h0A, 1'b0);
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL idle_drop_0A strobe got %b exp 0", i2c_wr_strobe); end
        send(8'hBB, 1'b0);
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL idle_drop_BB strobe got %b exp 0", i2c_wr_strobe); end
        n_vec++; if (reg_bank !== 128'h0) begin n_err++; $display("FAIL idle_drop_bank got %h exp 0", reg_bank); end
        send(8'h35, 1'b1);
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL ptr_byte_strobe got %b exp 0", i2c_wr_strobe); end
        send(8'hC4, 1'b0);
        exp_bank[5] = 8'hC4;
        n_vec++; if (i2c_wr_strobe !== 1'b1 || i2c_wr_addr !== 4'h5) begin n_err++; $display("FAIL ptr_mask_strobe got %b/%h exp 1/5", i2c_wr_strobe, i2c_wr_addr); end
        n_vec++; if (reg_bank !== exp_flat()) begin n_err++; $display("FAIL ptr_mask_bank got %h exp %h", reg_bank, exp_flat()); end
    endtask

    task automatic test_stream();
        send(8'h03, 1'b1);
        send(8'hAA, 1'b0);
        n_vec++; if (i2c_wr_strobe !== 1'b1 || i2c_wr_addr !== 4'h3) begin n_err++; $display("FAIL stream_wr1 got %b/%h exp 1/3", i2c_wr_strobe, i2c_wr_addr); end
        send(8'h55, 1'b0);
        e4 = AUTO ? 4'h4 : 4'h3;
        n_vec++; if (i2c_wr_strobe !== 1'b1 || i2c_wr_addr !== e4) begin n_err++; $display("FAIL stream_wr2 got %b/%h exp 1/%h", i2c_wr_strobe, i2c_wr_addr, e4); end
        exp_bank[3] = AUTO ? 8'hAA : 8'h55;
        exp_bank[4] = AUTO ? 8'h55 : 8'h00;
        n_vec++; if (reg_bank !== exp_flat()) begin n_err++; $display("FAIL stream_bank got %h exp %h", reg_bank, exp_flat()); end
        tick();
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL stream_strobe_pulse got %b exp 0", i2c_wr_strobe); end
    endtask

    task automatic test_wrap();
        send(8'h0F, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        e4 = AUTO ? 4'h0 : 4'hF;
        n_vec++; if (i2c_wr_addr !== e4) begin n_err++; $display("FAIL wrap_addr got %h exp %h", i2c_wr_addr, e4); end
        exp_bank[15] = AUTO ? 8'h11 : 8'h22;
        exp_bank[0]  = AUTO ? 8'h22 : 8'h00;
        n_vec++; if (reg_bank !== exp_flat()) begin n_err++; $display("FAIL wrap_bank got %h exp %h", reg_bank, exp_flat()); end
    endtask

    task automatic test_read();
        send(8'h02, 1'b1);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        exp_bank[2] = AUTO ? 8'h12 : 8'h34;
        exp_bank[3] = AUTO ? 8'h34 : exp_bank[3];
        send(8'h02, 1'b1);
        fifo_ren = 1'b1;
        tick();
        fifo_ren = 1'b0;
        e8 = AUTO ? 8'h12 : 8'h34;
        n_vec++; if (fifo_rdata !== e8) begin n_err++; $display("FAIL read1 got %h exp %h", fifo_rdata, e8); end
        tick();
        n_vec++; if (fifo_rdata !== e8) begin n_err++; $display("FAIL read1_hold got %h exp %h", fifo_rdata, e8); end
        fifo_ren = 1'b1;
        tick();
        fifo_ren = 1'b0;
        n_vec++; if (fifo_rdata !== 8'h34) begin n_err++; $display("FAIL read2 got %h exp 34", fifo_rdata); end
    endtask

    task automatic test_host_defer();
        send(8'h08, 1'b1);
        fifo_wen = 1'b1; fifo_wdata = 8'h99; fifo_wdata_start = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'h5; host_wdata = 8'h77;
        tick();
        fifo_wen = 1'b0;
        n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL defer_no_ack got %b exp 0", host_ack); end
        n_vec++; if (i2c_wr_strobe !== 1'b1 || i2c_wr_addr !== 4'h8) begin n_err++; $display("FAIL defer_i2c_wr got %b/%h exp 1/8", i2c_wr_strobe, i2c_wr_addr); end
        tick();
        host_req = 1'b0;
        n_vec++; if (host_ack !== 1'b1) begin n_err++; $display("FAIL defer_ack got %b exp 1", host_ack); end
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL host_wr_no_strobe got %b exp 0", i2c_wr_strobe); end
        exp_bank[8] = 8'h99;
        exp_bank[5] = 8'h77;
        n_vec++; if (reg_bank !== exp_flat()) begin n_err++; $display("FAIL defer_bank got %h exp %h", reg_bank, exp_flat()); end
        tick();
        n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL defer_ack_pulse got %b exp 0", host_ack); end
    endtask

    task automatic test_back_to_back();
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'h5;
        fifo_ren = 1'b1;
        tick();
        fifo_ren = 1'b0;
        host_addr = 4'h3;
        e8 = AUTO ? 8'h00 : 8'h99;
        n_vec++; if (fifo_rdata !== e8) begin n_err++; $display("FAIL dual_port_fifo_rdata got %h exp %h", fifo_rdata, e8); end
        n_vec++; if (host_ack !== 1'b1 || host_rdata !== 8'h77) begin n_err++; $display("FAIL b2b_ack1 got %b/%h exp 1/77", host_ack, host_rdata); end
        tick();
        n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b exp 0", host_ack); end
        tick();
        host_req = 1'b0;
        e8 = exp_bank[3];
        n_vec++; if (host_ack !== 1'b1 || host_rdata !== e8) begin n_err++; $display("FAIL b2b_ack2 got %b/%h exp 1/%h", host_ack, host_rdata, e8); end
        tick();
    endtask

    task automatic test_mid_reset();
        send(8'h04, 1'b1);
        fifo_wen = 1'b1; fifo_wdata = 8'h66; fifo_wdata_start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        fifo_wen = 1'b0;
        n_vec++; if (reg_bank !== 128'h0) begin n_err++; $display("FAIL midrst_bank got %h exp 0", reg_bank); end
        n_vec++; if (fifo_rdata !== 8'h00 || host_ack !== 1'b0) begin n_err++; $display("FAIL midrst_out got %h/%b exp 00/0", fifo_rdata, host_ack); end
        n_vec++; if (i2c_wr_strobe !== 1'b0) begin n_err++; $display("FAIL midrst_strobe got %b exp 0", i2c_wr_strobe); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
        send(8'h66, 1'b0);
        n_vec++; if (i2c_wr_strobe !== 1'b0 || reg_bank !== 128'h0) begin n_err++; $display("FAIL midrst_idle_drop got %b/%h exp 0/0", i2c_wr_strobe, reg_bank); end
    endtask

    initial begin
        rst = 1'b1;
        fifo_wen = 1'b0; fifo_wdata = 8'h00; fifo_wdata_start = 1'b0; fifo_ren = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
        for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
        test_reset();
        test_dropped_and_ptr_mask();
        test_stream();
        test_wrap();
        test_read();
        test_host_defer();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
